// File: rtl/lane_fleet.sv
// lane_fleet: one traffic lane that owns a row of evenly spaced cars plus a wrap buffer car.
// A SpawnEnable rise snapshots the lane config, a restoring divider works out the spacing,
// the cars are placed in one cycle and then move once per frame with wrap-around.
// The beam hit/tile/offset outputs are combinational so the compositor sees them in the same cycle.
module lane_fleet #(
  parameter int TileY       = 0,
  parameter int MaxCars     = 5,
  parameter int CarWidth    = 48,
  parameter int CarHeight   = 26,
  parameter int ScreenWidth = 640,
  parameter int Margin      = 100,
  parameter int PrioRow     = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_frame_tick,
  input  logic       i_spawn_enable,
  input  logic       i_direction,
  input  logic [1:0] i_car_type,
  input  logic [2:0] i_car_count,
  input  logic [2:0] i_car_speed,
  input  logic [9:0] i_draw_x,
  input  logic [9:0] i_draw_y,
  output logic       o_busy,
  output logic       o_car_pixel_c,
  output logic       o_car_priority_c,
  output logic [3:0] o_tile_c,
  output logic [5:0] o_pixel_x_c,
  output logic [4:0] o_pixel_y_c
);

  localparam int unsigned NumSlots = MaxCars + 1;
  localparam int unsigned XW       = 11;
  localparam int unsigned DivW     = 10;
  localparam int unsigned RemW     = DivW + 1;
  localparam int unsigned CntW     = 4;
  localparam int          WorldW   = ScreenWidth + 2 * Margin;
  localparam int          SpawnY   = 16 * TileY - (CarHeight - 16);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DIV   = 2'd1,
    S_PLACE = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_spawn_prev;
  logic                r_busy;
  logic                r_face_left;
  logic [1:0]          r_type;
  logic [2:0]          r_speed;
  logic [2:0]          r_n;
  logic [DivW-1:0]     r_quo;
  logic [DivW-1:0]     r_rem;
  logic [CntW-1:0]     r_div_cnt;
  logic [XW-1:0]       r_x [NumSlots];
  logic [NumSlots-1:0] r_active;

  logic                w_rise;
  logic                w_snap;
  logic                w_div_step;
  logic                w_place;
  logic                w_move;
  logic                w_clear;
  logic [2:0]          w_n_clamp;
  logic [DivW-1:0]     w_dividend;
  logic [3:0]          w_divisor;
  logic [RemW-1:0]     w_shift;
  logic                w_ge;
  logic [DivW-1:0]     w_spacing;
  logic [XW-1:0]       w_place_x [NumSlots];
  logic [XW-1:0]       w_moved_x [NumSlots];

  assign w_rise     = i_spawn_enable & ~r_spawn_prev;
  assign w_n_clamp  = (int'(i_car_count) > MaxCars) ? 3'(MaxCars) : i_car_count;
  assign w_dividend = DivW'(ScreenWidth - CarWidth * int'(w_n_clamp));
  assign w_divisor  = {1'b0, r_n} + 4'd1;
  assign w_shift    = {r_rem, r_quo[DivW-1]};
  assign w_ge       = (w_shift >= RemW'(w_divisor));
  assign w_spacing  = (r_n == 3'd0) ? DivW'(ScreenWidth) : r_quo;
  assign o_busy     = r_busy;

  // State register, SpawnEnable history and registered Busy
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_spawn_prev <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_spawn_prev <= i_spawn_enable;
      r_busy       <= (w_next == S_DIV) || (w_next == S_PLACE);
    end
  end

  // Next-state and datapath strobes; a low SpawnEnable aborts from any state
  always_comb begin
    w_next     = r_state;
    w_snap     = 1'b0;
    w_div_step = 1'b0;
    w_place    = 1'b0;
    w_move     = 1'b0;
    w_clear    = ~i_spawn_enable;
    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_next = S_DIV;
          w_snap = 1'b1;
        end
      end
      S_DIV: begin
        w_div_step = 1'b1;
        if (r_div_cnt == CntW'(DivW - 1)) w_next = S_PLACE;
      end
      S_PLACE: begin
        w_place = 1'b1;
        w_next  = S_RUN;
      end
      S_RUN: begin
        w_move = i_frame_tick;
      end
      default: w_next = S_IDLE;
    endcase
    if (!i_spawn_enable) begin
      w_next     = S_IDLE;
      w_snap     = 1'b0;
      w_div_step = 1'b0;
      w_place    = 1'b0;
      w_move     = 1'b0;
    end
  end

  // Lane config snapshot taken on the spawn rise
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_face_left <= 1'b0;
      r_type      <= 2'd0;
      r_speed     <= 3'd0;
      r_n         <= 3'd0;
    end else if (w_snap) begin
      r_face_left <= i_direction;
      r_type      <= i_car_type;
      r_speed     <= i_car_speed;
      r_n         <= w_n_clamp;
    end
  end

  // Restoring divider: dividend shifts out of r_quo as quotient bits shift in
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_quo     <= '0;
      r_rem     <= '0;
      r_div_cnt <= '0;
    end else if (w_snap) begin
      r_quo     <= w_dividend;
      r_rem     <= '0;
      r_div_cnt <= '0;
    end else if (w_div_step) begin
      r_rem     <= w_ge ? DivW'(w_shift - RemW'(w_divisor)) : DivW'(w_shift);
      r_quo     <= {r_quo[DivW-2:0], w_ge};
      r_div_cnt <= r_div_cnt + CntW'(1);
    end
  end

  // Placement and per-frame movement targets for every slot (slot 0 is the buffer car)
  always_comb begin
    for (int i = 0; i < int'(NumSlots); i++) begin
      int x;
      int sp;
      x  = int'(r_x[i]);
      sp = int'(r_speed);
      w_place_x[i] = XW'(Margin + i * int'(w_spacing) + (i - 1) * CarWidth);
      if (r_face_left) w_moved_x[i] = (x < sp) ? XW'(x + WorldW - sp) : XW'(x - sp);
      else             w_moved_x[i] = (x + sp >= WorldW) ? XW'(x + sp - WorldW) : XW'(x + sp);
    end
  end

  // Slot positions and active flags
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_active <= '0;
      for (int i = 0; i < int'(NumSlots); i++) r_x[i] <= '0;
    end else if (w_clear) begin
      r_active <= '0;
    end else if (w_place) begin
      for (int i = 0; i < int'(NumSlots); i++) begin
        r_x[i]      <= w_place_x[i];
        r_active[i] <= (i <= int'(r_n));
      end
    end else if (w_move) begin
      for (int i = 0; i < int'(NumSlots); i++) begin
        if (r_active[i]) r_x[i] <= w_moved_x[i];
      end
    end
  end

  // Beam hit test; the lowest slot index wins where cars overlap
  always_comb begin
    int   wx;
    int   dy;
    logic found;
    o_car_pixel_c    = 1'b0;
    o_car_priority_c = 1'b0;
    o_tile_c         = 4'd0;
    o_pixel_x_c      = 6'd0;
    o_pixel_y_c      = 5'd0;
    found            = 1'b0;
    wx               = int'(i_draw_x) + Margin;
    dy               = int'(i_draw_y) - SpawnY;
    if (r_state == S_RUN && dy >= 0 && dy < CarHeight) begin
      for (int i = 0; i < int'(NumSlots); i++) begin
        if (!found && r_active[i] && wx >= int'(r_x[i]) && wx < int'(r_x[i]) + CarWidth) begin
          found            = 1'b1;
          o_car_pixel_c    = 1'b1;
          o_car_priority_c = (dy >= PrioRow);
          o_tile_c         = {1'b0, r_type, r_face_left};
          o_pixel_x_c      = 6'(wx - int'(r_x[i]));
          o_pixel_y_c      = 5'(dy);
        end
      end
    end
  end

endmodule

// File: tb/tb_lane_fleet.sv
// Directed bench for lane_fleet with default parameters (W=840, SpawnY=-10).
module tb_lane_fleet;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_frame_tick;
  logic       i_spawn_enable;
  logic       i_direction;
  logic [1:0] i_car_type;
  logic [2:0] i_car_count;
  logic [2:0] i_car_speed;
  logic [9:0] i_draw_x;
  logic [9:0] i_draw_y;
  logic       o_busy;
  logic       o_car_pixel_c;
  logic       o_car_priority_c;
  logic [3:0] o_tile_c;
  logic [5:0] o_pixel_x_c;
  logic [4:0] o_pixel_y_c;

  int checks = 0;
  int errors = 0;

  lane_fleet dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_frame_tick     (i_frame_tick),
    .i_spawn_enable   (i_spawn_enable),
    .i_direction      (i_direction),
    .i_car_type       (i_car_type),
    .i_car_count      (i_car_count),
    .i_car_speed      (i_car_speed),
    .i_draw_x         (i_draw_x),
    .i_draw_y         (i_draw_y),
    .o_busy           (o_busy),
    .o_car_pixel_c    (o_car_pixel_c),
    .o_car_priority_c (o_car_priority_c),
    .o_tile_c         (o_tile_c),
    .o_pixel_x_c      (o_pixel_x_c),
    .o_pixel_y_c      (o_pixel_y_c)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input int n);
    repeat (n) begin
      i_frame_tick = 1'b1;
      @(negedge clk);
      i_frame_tick = 1'b0;
    end
  endtask

  task automatic probe(input string tag, input int dx, input int dy, input bit hit,
                       input int px, input int py, input bit prio, input int tile);
    i_draw_x = 10'(dx);
    i_draw_y = 10'(dy);
    #1;
    chk({tag, ".pix"},  32'(o_car_pixel_c),    32'(hit));
    chk({tag, ".px"},   32'(o_pixel_x_c),      32'(px));
    chk({tag, ".py"},   32'(o_pixel_y_c),      32'(py));
    chk({tag, ".prio"}, 32'(o_car_priority_c), 32'(prio));
    chk({tag, ".tile"}, 32'(o_tile_c),         32'(tile));
  endtask

  // Raise SpawnEnable with the given config and measure the Busy window
  task automatic spawn(input string tag, input int cnt, input bit dir, input int typ, input int spd);
    int n;
    n              = 0;
    i_car_count    = 3'(cnt);
    i_direction    = dir;
    i_car_type     = 2'(typ);
    i_car_speed    = 3'(spd);
    i_spawn_enable = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (o_busy) n++;
      else if (n > 0) break;
    end
    chk({tag, ".busy_len"}, 32'(n), 32'd11);
    chk({tag, ".busy_end"}, 32'(o_busy), 32'd0);
  endtask

  task automatic despawn();
    i_spawn_enable = 1'b0;
    cycles(2);
  endtask

  initial begin
    int any;
    rst            = 1'b1;
    i_frame_tick   = 1'b0;
    i_spawn_enable = 1'b0;
    i_direction    = 1'b0;
    i_car_type     = 2'd0;
    i_car_count    = 3'd0;
    i_car_speed    = 3'd0;
    i_draw_x       = 10'd0;
    i_draw_y       = 10'd0;
    cycles(2);
    chk("rst.busy", 32'(o_busy), 32'd0);
    probe("rst", 124, 10, 0, 0, 0, 0, 0);
    rst = 1'b0;
    cycles(2);

    // N=3, speed 0: X = {52,224,396,568}, spacing 124
    spawn("n3", 3, 1'b0, 2, 0);
    probe("n3.s1_left",  124, 10, 1, 0, 20, 1, 4);
    probe("n3.gap",      123, 10, 0, 0, 0, 0, 0);
    probe("n3.s1_right", 171, 0,  1, 47, 10, 0, 4);
    probe("n3.s1_past",  172, 0,  0, 0, 0, 0, 0);
    probe("n3.s2",       296, 15, 1, 0, 25, 1, 4);
    probe("n3.s3_edge",  515, 5,  1, 47, 15, 0, 4);
    probe("n3.below",    124, 16, 0, 0, 0, 0, 0);
    // Config changes after the snapshot must not matter
    i_car_count = 3'd1;
    i_direction = 1'b1;
    i_car_type  = 2'd3;
    i_car_speed = 3'd7;
    frame(3);
    probe("n3.frozen", 124, 10, 1, 0, 20, 1, 4);
    despawn();
    chk("idle.busy", 32'(o_busy), 32'd0);
    probe("idle", 124, 10, 0, 0, 0, 0, 0);

    // CarCount=7 clamps to 5: spacing 66, X = {52,166,280,394,508,622}
    spawn("n5", 7, 1'b1, 1, 0);
    probe("n5.s1",      66,  10, 1, 0, 20, 1, 3);
    probe("n5.gap",     65,  10, 0, 0, 0, 0, 0);
    probe("n5.s3",      294, 10, 1, 0, 20, 1, 3);
    probe("n5.s5",      522, 10, 1, 0, 20, 1, 3);
    probe("n5.s5_past", 570, 10, 0, 0, 0, 0, 0);
    probe("n5.no_s6",   636, 10, 0, 0, 0, 0, 0);
    probe("n5.no_s7",   750, 10, 0, 0, 0, 0, 0);
    despawn();

    // Abort during DIV
    i_car_count    = 3'd3;
    i_direction    = 1'b0;
    i_car_type     = 2'd2;
    i_car_speed    = 3'd0;
    i_spawn_enable = 1'b1;
    cycles(4);
    chk("abort.busy_mid", 32'(o_busy), 32'd1);
    i_spawn_enable = 1'b0;
    cycles(1);
    chk("abort.busy_low", 32'(o_busy), 32'd0);
    cycles(12);
    any = 0;
    i_draw_y = 10'd10;
    for (int x = 0; x < 1024; x++) begin
      i_draw_x = 10'(x);
      #1;
      if (o_car_pixel_c !== 1'b0) any++;
    end
    chk("abort.no_pixel", 32'(any), 32'd0);
    chk("abort.busy_end", 32'(o_busy), 32'd0);
    cycles(1);

    // Left, speed 7, N=0: buffer car 52 -> 3 after 7 frames, wraps to 836 on the 8th
    spawn("left", 0, 1'b1, 3, 7);
    frame(8);
    probe("left.wrap",      736, 10, 1, 0, 20, 1, 7);
    probe("left.wrap_edge", 735, 10, 0, 0, 0, 0, 0);
    frame(1);
    probe("left.after", 736, 10, 1, 7, 20, 1, 7);
    despawn();

    // Right, speed 7, N=0: 52 -> 101 (7 frames) -> 836 (112) -> 3 (113) -> 101 (127)
    spawn("right", 0, 1'b0, 1, 7);
    probe("right.start", 0, 10, 0, 0, 0, 0, 0);
    frame(7);
    probe("right.enter", 1, 10, 1, 0, 20, 1, 2);
    probe("right.enter_edge", 0, 10, 0, 0, 0, 0, 0);
    frame(105);
    probe("right.pre_wrap", 736, 10, 1, 0, 20, 1, 2);
    probe("right.pre_wrap_end", 783, 10, 1, 47, 20, 1, 2);
    frame(1);
    probe("right.wrapped_gone", 743, 10, 0, 0, 0, 0, 0);
    probe("right.wrapped_left", 0, 10, 0, 0, 0, 0, 0);
    frame(14);
    probe("right.reenter", 1, 10, 1, 0, 20, 1, 2);

    // Asynchronous reset while running
    #2;
    rst = 1'b1;
    #1;
    chk("areset.pix",  32'(o_car_pixel_c),    32'd0);
    chk("areset.busy", 32'(o_busy),           32'd0);
    chk("areset.tile", 32'(o_tile_c),         32'd0);
    chk("areset.prio", 32'(o_car_priority_c), 32'd0);
    i_spawn_enable = 1'b0;
    cycles(2);
    rst = 1'b0;
    frame(5);
    probe("areset.after_a", 1,  10, 0, 0, 0, 0, 0);
    probe("areset.after_b", 36, 10, 0, 0, 0, 0, 0);
    chk("areset.busy_after", 32'(o_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
